iiitb_mem_arbiter: RTL and testbench
====================================

IIITB_MEM_ARBITER -- requirements
Module: iiitb_mem_arbiter

Interface
REQ-001 Parameter AW, default 5: memory word-address width (32 words).
REQ-002 Parameter DW, default 32: data word width.
REQ-003 Parameter STARVE_MAX, default 3: consecutive fetch denials before fetch is forced to win.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1: single clock; all state updates on its rising edge.
REQ-006 RN  in  1: reset, asynchronous assert, active-low.
REQ-007 if_req  in  1: fetch read request; held until if_gnt.
REQ-008 if_addr  in  AW: fetch word address; stable while if_req.
REQ-009 if_gnt  out  1: fetch request accepted this cycle (combinational).
REQ-010 if_rvalid  out  1: fetch read data valid (registered).
REQ-011 if_rdata  out  DW: fetch read data.
REQ-012 if_flush  in  1: branch redirect; discards an in-flight fetch response.
REQ-013 d_req  in  1: load/store request; held until d_gnt.
REQ-014 d_we  in  1: 1 = store, 0 = load.
REQ-015 d_addr  in  AW: data word address.
REQ-016 d_wdata  in  DW: store data.
REQ-017 d_gnt  out  1: data request accepted this cycle (combinational).
REQ-018 d_rvalid  out  1: load data valid, or store-complete acknowledge (registered).
REQ-019 d_rdata  out  DW: load data; 0 on store acknowledge.
REQ-020 m_en, m_we  out  1: single-port memory enable / write enable.
REQ-021 m_addr  out  AW; m_wdata  out  DW; m_rdata  in  DW: memory returns m_rdata one cycle after m_en.
REQ-022 conflict_cnt  out  16: saturating count of cycles with if_req and d_req both high.

Function
REQ-023 At most one of if_gnt/d_gnt SHALL be high per cycle; m_en = if_gnt | d_gnt.
REQ-024 A sole requester SHALL be granted in the same cycle.
REQ-025 On conflict, d_req SHALL win unless starve_cnt == STARVE_MAX, in which case if_req wins.
REQ-026 starve_cnt SHALL increment, saturating at STARVE_MAX, each cycle if_req is high and if_gnt is low; it clears on if_gnt.
REQ-027 m_addr/m_we/m_wdata SHALL be muxed from the granted port; m_we = d_gnt & d_we.
REQ-028 Response FSM states: RSP_NONE, RSP_IF, RSP_D. The next state SHALL be RSP_IF on if_gnt, RSP_D on d_gnt, and RSP_NONE otherwise.
REQ-029 In RSP_IF: if_rvalid = 1 and if_rdata = m_rdata, unless a flush is pending (REQ-031).
REQ-030 In RSP_D: d_rvalid = 1; d_rdata = m_rdata for a load, 0 for a store.
REQ-031 if_flush high in the grant cycle or the response cycle SHALL suppress that if_rvalid. Flush does not affect a data response or arbitration.
REQ-032 Latency: request to rvalid is exactly 1 cycle when granted immediately. Back-to-back grants SHALL give full throughput.
REQ-033 conflict_cnt SHALL saturate at 16'hFFFF without wrapping.
REQ-034 rdata outputs SHALL be 0 whenever the matching rvalid is low.

Reset
REQ-035 When RN is low, the block SHALL asynchronously force: FSM to RSP_NONE, starve_cnt = 0, conflict_cnt = 0, all rvalid = 0, all rdata = 0.
REQ-036 While RN is low, if_gnt, d_gnt, m_en and m_we SHALL be 0, and a response in flight is dropped.
REQ-037 Arbitration SHALL resume on the first rising edge after RN returns high.

Structure
REQ-038 Shared package iiitb_pkg SHALL hold the response-state enum (RSP_NONE/RSP_IF/RSP_D) and the AW/DW/STARVE_MAX defaults.
REQ-039 The saturating starvation counter SHALL be the sub-module iiitb_starve_cnt (inputs inc, clr; output at_max).

Verification
REQ-040 if_req=1, addr=3, memory[3]=32'h02208300 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=32'h02208300.
REQ-041 Both requesting continuously, d_we=0 -> d_gnt for 3 cycles, then if_gnt on the 4th cycle; starve_cnt returns to 0.
REQ-042 d_req store addr=2, wdata=32'd3, then load addr=2 next cycle -> store ack d_rdata=0; load d_rvalid with d_rdata=32'd3.
REQ-043 if_gnt at addr 9, if_flush=1 in the following cycle -> no if_rvalid; a d_gnt in that cycle still returns d_rvalid.
REQ-044 RN pulled low in a response cycle -> rvalid drops immediately; conflict_cnt=0; first grant after release behaves as in REQ-040.
REQ-045 Force conflict_cnt to 16'hFFFE, then 3 conflict cycles -> conflict_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/iiitb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default geometry,
// response-state encoding and a 16-bit saturating increment.
package iiitb_pkg;

    localparam int AW_DEFAULT         = 5;
    localparam int DW_DEFAULT         = 32;
    localparam int STARVE_MAX_DEFAULT = 3;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/iiitb_starve_cnt.sv
// Saturating count of consecutive fetch denials; at_max tells the arbiter
// that fetch must win the next conflict.
module iiitb_starve_cnt #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != CW'(MAX))) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_max = (cnt_reg == CW'(MAX));

endmodule

// File: rtl/iiitb_mem_arbiter.sv
// Fetch/data arbiter in front of a single-port synchronous memory. Data wins
// conflicts unless fetch has been denied STARVE_MAX cycles in a row.
module iiitb_mem_arbiter
    import iiitb_pkg::*;
#(
    parameter int AW         = AW_DEFAULT,
    parameter int DW         = DW_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          if_flush,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [15:0]   conflict_cnt
);

    logic       starve_at_max;
    logic       both_req;
    logic       if_wins;

    rsp_state_t state_reg;
    rsp_state_t state_next;
    logic       d_store_reg;
    logic       flush_reg;
    logic [15:0] conflict_reg;

    assign both_req = if_req & d_req;
    assign if_wins  = if_req & (~d_req | starve_at_max);

    // Grants are gated by RN so nothing reaches the memory while in reset.
    assign if_gnt = RN & if_wins;
    assign d_gnt  = RN & d_req & ~if_wins;

    assign m_en    = if_gnt | d_gnt;
    assign m_we    = d_gnt & d_we;
    assign m_addr  = d_gnt ? d_addr : if_addr;
    assign m_wdata = d_gnt ? d_wdata : '0;

    iiitb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (clk),
        .rst_n  (RN),
        .inc    (if_req & ~if_gnt),
        .clr    (if_gnt),
        .at_max (starve_at_max)
    );

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_reg    <= RSP_NONE;
            d_store_reg  <= 1'b0;
            flush_reg    <= 1'b0;
            conflict_reg <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            d_store_reg  <= d_gnt & d_we;
            flush_reg    <= if_gnt & if_flush;
            conflict_reg <= both_req ? sat_inc16(conflict_reg) : conflict_reg;
        end
    end

    // A flush seen in either the grant cycle or the response cycle kills the fetch response.
    always_comb begin
        state_next = RSP_NONE;
        if_rvalid  = 1'b0;
        if_rdata   = '0;
        d_rvalid   = 1'b0;
        d_rdata    = '0;

        if (if_gnt) begin
            state_next = RSP_IF;
        end else if (d_gnt) begin
            state_next = RSP_D;
        end

        case (state_reg)
            RSP_IF: begin
                if (!flush_reg && !if_flush) begin
                    if_rvalid = 1'b1;
                    if_rdata  = m_rdata;
                end
            end
            RSP_D: begin
                d_rvalid = 1'b1;
                d_rdata  = d_store_reg ? '0 : m_rdata;
            end
            default: begin
            end
        endcase
    end

    assign conflict_cnt = conflict_reg;

endmodule

// File: tb/tb_iiitb_mem_arbiter.sv
// Scoreboard bench for iiitb_mem_arbiter: a reference model pushes expected
// grants/responses, a separate monitor pops and compares each cycle.
module tb_iiitb_mem_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          RN = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [DW-1:0] if_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata;
    logic [15:0]   conflict_cnt;

    iiitb_mem_arbiter dut (
        .clk          (clk),
        .RN           (RN),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_flush     (if_flush),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .m_en         (m_en),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memval(input int i);
        if (i == 3) return 32'h02208300;
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0000;
    endfunction

    // Memory behind the arbiter: one-cycle registered read, reloaded during reset.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (!RN) begin
            for (int i = 0; i < 32; i++) mem[i] <= memval(i);
            m_rdata <= '0;
        end else if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            m_rdata <= mem[m_addr];
        end
    end

    typedef struct {
        int unsigned due;
        logic        ig;
        logic        dg;
        logic        we;
        logic [15:0] conf;
    } grant_t;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] data;
        logic          fl;
    } rsp_t;

    grant_t gq[$];
    rsp_t   if_q[$];
    rsp_t   d_q[$];

    // Reference model state
    logic [DW-1:0] ref_mem [32];
    int            starve_m = 0;
    int            conf_m = 0;
    logic          ifw, dw;
    grant_t        g_m;
    logic          last_if_gnt = 1'b0;
    logic          last_d_gnt = 1'b0;

    always @(negedge clk) begin
        if (!RN) begin
            for (int i = 0; i < 32; i++) ref_mem[i] = memval(i);
            starve_m = 0;
            conf_m = 0;
            if_q.delete();
            d_q.delete();
            g_m = '{due: cyc, ig: 1'b0, dg: 1'b0, we: 1'b0, conf: 16'h0};
            last_if_gnt = 1'b0;
            last_d_gnt = 1'b0;
        end else begin
            ifw = if_req && (!d_req || starve_m == SMAX);
            dw  = d_req && !ifw;
            g_m = '{due: cyc, ig: ifw, dg: dw, we: dw && d_we, conf: 16'(conf_m)};
            if (if_req && d_req && conf_m < 65535) conf_m++;
            if (ifw) starve_m = 0;
            else if (if_req && starve_m < SMAX) starve_m++;
            if (ifw) if_q.push_back('{due: cyc + 1, data: ref_mem[if_addr], fl: if_flush});
            if (dw) begin
                if (d_we) begin
                    ref_mem[d_addr] = d_wdata;
                    d_q.push_back('{due: cyc + 1, data: '0, fl: 1'b0});
                end else begin
                    d_q.push_back('{due: cyc + 1, data: ref_mem[d_addr], fl: 1'b0});
                end
            end
            last_if_gnt = ifw;
            last_d_gnt = dw;
        end
        gq.push_back(g_m);
    end

    // Monitor
    int     n_cmp = 0;
    int     n_err = 0;
    logic   verbose = 1'b1;
    grant_t g_c;
    rsp_t   r_c;
    logic   ev;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (gq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_record cyc=%0d got=none want=one", cyc);
        end else begin
            g_c = gq.pop_front();
            chk("if_gnt", 32'(if_gnt), 32'(g_c.ig));
            chk("d_gnt", 32'(d_gnt), 32'(g_c.dg));
            chk("m_en", 32'(m_en), 32'(g_c.ig | g_c.dg));
            chk("m_we", 32'(m_we), 32'(g_c.we));
            chk("conflict_cnt", 32'(conflict_cnt), 32'(g_c.conf));
        end

        if (if_q.size() > 0 && if_q[0].due == cyc) begin
            r_c = if_q.pop_front();
            ev = !r_c.fl && !if_flush;
            chk("if_rvalid", 32'(if_rvalid), 32'(ev));
            chk("if_rdata", if_rdata, ev ? r_c.data : '0);
            if (verbose) $display("fetch rsp cyc=%0d valid=%0b data=%h", cyc, if_rvalid, if_rdata);
        end else begin
            chk("if_rvalid_idle", 32'(if_rvalid), 32'd0);
            chk("if_rdata_idle", if_rdata, 32'd0);
        end

        if (d_q.size() > 0 && d_q[0].due == cyc) begin
            r_c = d_q.pop_front();
            chk("d_rvalid", 32'(d_rvalid), 32'd1);
            chk("d_rdata", d_rdata, r_c.data);
            if (verbose) $display("data rsp cyc=%0d valid=%0b data=%h", cyc, d_rvalid, d_rdata);
        end else begin
            chk("d_rvalid_idle", 32'(d_rvalid), 32'd0);
            chk("d_rdata_idle", d_rdata, 32'd0);
        end
    end

    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr, input logic dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd, input logic fl);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dd; if_flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    task automatic random_run(input int cycles, input logic both);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (!if_req || last_if_gnt) begin
                if_req  = both || ($urandom_range(0, 1) == 1);
                if_addr = AW'($urandom_range(0, 31));
            end
            if (!d_req || last_d_gnt) begin
                d_req   = both || ($urandom_range(0, 1) == 1);
                d_we    = !both && ($urandom_range(0, 2) == 0);
                d_addr  = AW'($urandom_range(0, 7));
                d_wdata = $urandom;
            end
            if_flush = !both && ($urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        RN = 1'b0;
        repeat (3) @(posedge clk);
        #1 RN = 1'b1;

        // single fetch from word 3
        drive(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        idle();
        // continuous conflict: three data wins, then fetch
        repeat (4) drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd4, 32'd0, 1'b0);
        idle();
        // store then load of word 2
        drive(1'b0, 5'd0, 1'b1, 1'b1, 5'd2, 32'd3, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 32'd0, 1'b0);
        idle();
        // flush in response cycle while a load is granted
        drive(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        drive(1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 32'd0, 1'b1);
        idle();
        // flush in grant cycle
        drive(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        idle();
        idle();
        // reset asserted during a fetch response
        drive(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        RN = 1'b0;
        d_req = 1'b1;
        d_addr = 5'd1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        RN = 1'b1;
        d_req = 1'b0;
        idle();
        idle();

        random_run(600, 1'b0);
        idle();
        idle();

        // sustained conflict to saturate conflict_cnt
        verbose = 1'b0;
        random_run(65545, 1'b1);
        idle();
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
